// File: rtl/exalu_seq.sv
`default_nettype none
// ============================================================================
// exalu_seq : sequencing extended ALU for single-cycle wide ops and engine ops
// Revision  : 1.0  initial release
// Optional  : EXALU_TIMEOUT_EN adds an engine wait limit of TIMEOUT cycles
// ============================================================================
module exalu_seq #(
   parameter int XLEN    = 256,
   parameter int ENG_W   = 128,
   parameter int NUM_ENG = 2,
   parameter int OP_W    = 3,
   parameter int LANE_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clock_i,
   input  logic                     resetN_i,
   input  logic                     req_i,
   output logic                     ready_o,
   input  logic [OP_W-1:0]          op_i,
   input  logic [XLEN-1:0]          d1_i,
   input  logic [XLEN-1:0]          d2_i,
   output logic                     respValid_o,
   input  logic                     respReady_i,
   output logic [XLEN-1:0]          result_o,
   output logic                     error_o,
   output logic                     busy_o,
   output logic [NUM_ENG-1:0]       engStart_o,
   output logic [ENG_W-1:0]         engIn1_o,
   output logic [ENG_W-1:0]         engIn2_o,
   input  logic [NUM_ENG-1:0]       engBusy_i,
   input  logic [NUM_ENG*ENG_W-1:0] engOut_i
);

   localparam int              c_SEL_W       = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
   localparam logic [OP_W-1:0] c_OP_NOP      = '0;
   localparam logic [OP_W-1:0] c_OP_LAST_ENG = OP_W'(NUM_ENG);
   localparam logic [OP_W-1:0] c_OP_EXTRACT  = OP_W'(NUM_ENG + 1);
   localparam logic [OP_W-1:0] c_OP_BYTELD   = OP_W'(NUM_ENG + 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [XLEN-1:0]      result_q, result_d;
   logic                 error_q, error_d;
   logic [c_SEL_W-1:0]   sel_q, sel_d;
   logic [ENG_W-1:0]     eng1_q, eng1_d;
   logic [ENG_W-1:0]     eng2_q, eng2_d;

`ifdef EXALU_TIMEOUT_EN
   localparam int        c_CNT_W = $clog2(TIMEOUT + 1);
   logic [c_CNT_W-1:0]   cnt_q, cnt_d;
`endif

   logic                 w_is_eng;
   logic [XLEN-1:0]      w_shift;
   logic [XLEN-1:0]      w_ext;
   logic [XLEN-1:0]      w_imm_res;
   logic                 w_imm_err;
   logic [ENG_W-1:0]     w_eng_sel;

   assign w_is_eng  = (op_i != c_OP_NOP) && (op_i <= c_OP_LAST_ENG);
   assign w_shift   = d1_i >> d2_i;
   assign w_ext     = (d2_i >= XLEN'(XLEN)) ? '0 : XLEN'(w_shift[LANE_W-1:0]);
   assign w_eng_sel = engOut_i[sel_q*ENG_W +: ENG_W];

   // Result of every op that completes without an engine, from live inputs at accept.
   always_comb begin
      w_imm_res = '0;
      w_imm_err = 1'b0;
      if (op_i == c_OP_EXTRACT) begin
         w_imm_res = w_ext;
      end else if (op_i == c_OP_BYTELD) begin
         w_imm_res = {d1_i[XLEN-9:0], d2_i[7:0]};
      end else if ((op_i != c_OP_NOP) && !w_is_eng) begin
         w_imm_err = 1'b1;
      end
   end

   always_ff @(posedge clock_i or negedge resetN_i) begin
      if (!resetN_i) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         error_q  <= 1'b0;
         sel_q    <= '0;
         eng1_q   <= '0;
         eng2_q   <= '0;
`ifdef EXALU_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         error_q  <= error_d;
         sel_q    <= sel_d;
         eng1_q   <= eng1_d;
         eng2_q   <= eng2_d;
`ifdef EXALU_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      error_d  = error_q;
      sel_d    = sel_q;
      eng1_d   = eng1_q;
      eng2_d   = eng2_q;
`ifdef EXALU_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               eng1_d = d1_i[ENG_W-1:0];
               eng2_d = d2_i[ENG_W-1:0];
               if (w_is_eng) begin
                  sel_d   = c_SEL_W'(op_i - 1'b1);
                  state_d = S_START;
               end else begin
                  result_d = w_imm_res;
                  error_d  = w_imm_err;
                  state_d  = S_DONE;
               end
            end
         end
         S_START: begin
            state_d = S_WAIT;
`ifdef EXALU_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (!engBusy_i[sel_q]) begin
               result_d = XLEN'(w_eng_sel);
               error_d  = 1'b0;
               state_d  = S_DONE;
`ifdef EXALU_TIMEOUT_EN
            // The TIMEOUT-th WAIT cycle with the engine still busy gives up.
            end else if (cnt_q == c_CNT_W'(TIMEOUT - 1)) begin
               result_d = '0;
               error_d  = 1'b1;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         S_DONE: begin
            if (respReady_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ready_o     = (state_q == S_IDLE);
   assign respValid_o = (state_q == S_DONE);
   assign result_o    = result_q;
   assign error_o     = error_q;
   assign busy_o      = (state_q != S_IDLE) || (|engBusy_i);
   assign engStart_o  = (state_q == S_START) ? (NUM_ENG'(1) << sel_q) : '0;
   assign engIn1_o    = eng1_q;
   assign engIn2_o    = eng2_q;

endmodule
`default_nettype wire

// File: tb/tb_exalu_seq.sv
`default_nettype none
// ============================================================================
// tb_exalu_seq : directed and random checks of exalu_seq against a reference
// Revision     : 1.0  initial release
// ============================================================================
module tb_exalu_seq;

   localparam int XLEN    = 256;
   localparam int ENG_W   = 128;
   localparam int NUM_ENG = 2;
   localparam int OP_W    = 3;
   localparam int LANE_W  = 32;
   localparam int TIMEOUT = 16;

   logic                     clock = 1'b0;
   logic                     resetN = 1'b0;
   logic                     req = 1'b0;
   logic                     ready;
   logic [OP_W-1:0]          op = '0;
   logic [XLEN-1:0]          d1 = '0;
   logic [XLEN-1:0]          d2 = '0;
   logic                     respValid;
   logic                     respReady = 1'b0;
   logic [XLEN-1:0]          result;
   logic                     error;
   logic                     busy;
   logic [NUM_ENG-1:0]       engStart;
   logic [ENG_W-1:0]         engIn1;
   logic [ENG_W-1:0]         engIn2;
   logic [NUM_ENG-1:0]       engBusy;
   logic [NUM_ENG*ENG_W-1:0] engOut;

   int errors = 0;
   int checks = 0;

   exalu_seq #(
      .XLEN(XLEN), .ENG_W(ENG_W), .NUM_ENG(NUM_ENG),
      .OP_W(OP_W), .LANE_W(LANE_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock_i(clock), .resetN_i(resetN), .req_i(req), .ready_o(ready),
      .op_i(op), .d1_i(d1), .d2_i(d2), .respValid_o(respValid),
      .respReady_i(respReady), .result_o(result), .error_o(error),
      .busy_o(busy), .engStart_o(engStart), .engIn1_o(engIn1),
      .engIn2_o(engIn2), .engBusy_i(engBusy), .engOut_i(engOut)
   );

   always #5 clock = ~clock;

   // Engine model: eng_len is the occupancy counted from the start cycle,
   // so busy is visible for eng_len-1 cycles starting the cycle after start.
   int               eng_cnt   [NUM_ENG] = '{default: 0};
   int               eng_len   [NUM_ENG] = '{default: 10};
   bit               stuck     [NUM_ENG] = '{default: 1'b0};
   int               start_cnt [NUM_ENG] = '{default: 0};
   logic [ENG_W-1:0] eng_val   [NUM_ENG] = '{default: '0};
   logic [ENG_W-1:0] cap1 = '0;
   logic [ENG_W-1:0] cap2 = '0;

   always @(posedge clock) begin
      for (int k = 0; k < NUM_ENG; k++) begin
         if (engStart[k]) begin
            eng_cnt[k]   <= eng_len[k] - 1;
            start_cnt[k] <= start_cnt[k] + 1;
            cap1         <= engIn1;
            cap2         <= engIn2;
         end else if (eng_cnt[k] > 0) begin
            eng_cnt[k] <= eng_cnt[k] - 1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_ENG; k++) begin
         engBusy[k]                 = stuck[k] || (eng_cnt[k] != 0);
         engOut[k*ENG_W +: ENG_W]   = eng_val[k];
      end
   end

   task automatic chk(input string tag, input logic [XLEN:0] obs, input logic [XLEN:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] rand_w();
      logic [XLEN-1:0] v;
      for (int i = 0; i < XLEN / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference: {error, result} straight from the opcode map.
   function automatic logic [XLEN:0] ref_model(input int opv, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
      logic [XLEN-1:0] one;
      logic [XLEN-1:0] m;
      one = 1;
      if (opv == 0) return '0;
      if (opv <= NUM_ENG) begin
         m = eng_val[opv-1];
         return {1'b0, m};
      end
      if (opv == NUM_ENG + 1) begin
         if (b >= XLEN) return '0;
         m = (a >> b) & ((one << LANE_W) - 1);
         return {1'b0, m};
      end
      if (opv == NUM_ENG + 2) begin
         m = a * 256 + (b % 256);
         return {1'b0, m};
      end
      return {1'b1, {XLEN{1'b0}}};
   endfunction

   task automatic run_op(input int opv, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input string tag);
      logic [XLEN:0] exp;
      int            exp_lat;
      int            lat;
      int            s0 [NUM_ENG];
      bit            is_eng;
      is_eng  = (opv >= 1) && (opv <= NUM_ENG);
      exp     = ref_model(opv, a, b);
      exp_lat = is_eng ? eng_len[opv-1] + 2 : 1;
      for (int k = 0; k < NUM_ENG; k++) s0[k] = start_cnt[k];
      @(negedge clock);
      req = 1'b1; op = opv[OP_W-1:0]; d1 = a; d2 = b;
      chk({tag, ".ready"}, {256'b0, ready}, 1);
      @(posedge clock);
      #1 req = 1'b0; d1 = ~a; d2 = ~b;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!respValid && lat < 200);
      chk({tag, ".res"}, {error, result}, exp);
      chk({tag, ".lat"}, lat, exp_lat);
      if (is_eng) begin
         for (int k = 0; k < NUM_ENG; k++)
            chk({tag, ".starts"}, start_cnt[k] - s0[k], (k == opv - 1) ? 1 : 0);
         chk({tag, ".in1"}, cap1, a[ENG_W-1:0]);
         chk({tag, ".in2"}, cap2, b[ENG_W-1:0]);
      end
      respReady = 1'b1;
      @(posedge clock);
      #1 respReady = 1'b0;
   endtask

   initial begin
      logic [XLEN-1:0] a, b, x, y;
      logic [XLEN:0]   exp;
      int              seen;
      int              lat;
      int              opv;

      // Reset with a pending request.
      req = 1'b1; op = 3'd3; d1 = rand_w(); d2 = 32;
      repeat (3) @(negedge clock);
      chk("rst.ready", ready, 1);
      chk("rst.valid", respValid, 0);
      chk("rst.result", {error, result}, 0);
      chk("rst.start", engStart, 0);
      chk("rst.engin", {engIn1, engIn2}, 0);
      req = 1'b0; resetN = 1'b1;
      @(negedge clock);

      a = rand_w(); a[63:0] = 64'hDEADBEEF_12345678;
      run_op(NUM_ENG + 1, a, 32, "extract32");
      chk("extract32.const", result, 256'hDEADBEEF);
      run_op(NUM_ENG + 2, 1, 256'h1AB, "byteld");
      chk("byteld.const", result, 256'h1AB);
      run_op(NUM_ENG + 1, rand_w(), 300, "extract300");
      run_op(NUM_ENG + 1, rand_w(), XLEN - LANE_W + 4, "extract_top");
      run_op(0, rand_w(), rand_w(), "nop");

      eng_len[0] = 10; eng_val[0] = 128'hCAFE;
      run_op(1, rand_w(), rand_w(), "eng0");
      chk("eng0.const", result, {128'b0, 128'hCAFE});

      // Backpressure with a second request already waiting.
      a = rand_w(); b = 40; x = rand_w(); y = rand_w();
      exp = ref_model(NUM_ENG + 1, a, b);
      @(negedge clock);
      req = 1'b1; op = OP_W'(NUM_ENG + 1); d1 = a; d2 = b;
      @(posedge clock);
      #1 op = OP_W'(NUM_ENG + 2); d1 = x; d2 = y;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("bp.hold", {error, result}, exp);
         chk("bp.ready", {respValid, ready}, 2'b10);
      end
      respReady = 1'b1;
      @(posedge clock);
      #1 respReady = 1'b0;
      @(negedge clock);
      chk("bp.idle", {respValid, ready}, 2'b01);
      @(posedge clock);
      #1 req = 1'b0;
      @(negedge clock);
      chk("bp.next_valid", respValid, 1);
      chk("bp.next_res", {error, result}, ref_model(NUM_ENG + 2, x, y));
      respReady = 1'b1;
      @(posedge clock);
      #1 respReady = 1'b0;

      run_op(7, rand_w(), rand_w(), "illegal7");
      run_op(NUM_ENG + 3, rand_w(), rand_w(), "illegal5");

      // Reset while waiting on the engine.
      eng_len[0] = 12;
      @(negedge clock);
      req = 1'b1; op = 3'd1; d1 = rand_w(); d2 = rand_w();
      @(posedge clock);
      #1 req = 1'b0;
      repeat (4) @(negedge clock);
      resetN = 1'b0;
      #1;
      chk("midrst.valid", respValid, 0);
      chk("midrst.ready", ready, 1);
      repeat (2) @(negedge clock);
      resetN = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (respValid) seen++;
      end
      chk("midrst.noresp", seen, 0);
      chk("midrst.ready2", ready, 1);

      // Engine that never finishes.
      stuck[0] = 1'b1;
      @(negedge clock);
      req = 1'b1; op = 3'd1; d1 = rand_w(); d2 = rand_w();
      @(posedge clock);
      #1 req = 1'b0;
`ifdef EXALU_TIMEOUT_EN
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!respValid && lat < 200);
      chk("tmo.res", {error, result}, {1'b1, {XLEN{1'b0}}});
      chk("tmo.lat", lat, TIMEOUT + 2);
      stuck[0] = 1'b0;
      respReady = 1'b1;
      @(posedge clock);
      #1 respReady = 1'b0;
`else
      seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (respValid) seen++;
      end
      chk("stuck.noresp", seen, 0);
      chk("stuck.busy", busy, 1);
      stuck[0] = 1'b0;
      resetN = 1'b0;
      @(negedge clock);
      resetN = 1'b1;
`endif
      repeat (15) @(negedge clock);

      // Random mix of every opcode.
      for (int i = 0; i < 40; i++) begin
         opv = $urandom_range(0, 7);
         for (int k = 0; k < NUM_ENG; k++) begin
            eng_len[k] = $urandom_range(2, 12);
            eng_val[k] = {$urandom, $urandom, $urandom, $urandom};
         end
         a = rand_w();
         b = (opv == NUM_ENG + 1) ? XLEN'($urandom_range(0, 300)) : rand_w();
         run_op(opv, a, b, $sformatf("rand%0d_op%0d", i, opv));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/exalu_seq.md
# exalu_seq

Parametrised sequencing extended-ALU for the wide (XLEN) register datapath. It accepts one extended operation at a time over a valid/ready request handshake. It runs either a single-cycle wide operation (lane extract, byte shift-in) or a multi-cycle operation on one of NUM_ENG external crypto engines (AES encrypt/decrypt and successors), and returns the result over a valid/ready response handshake. It sits between the decode/register-read stage and the engine array, replacing ad-hoc per-engine state tracking with one FSM.

## Interface
- XLEN, 256, wide register width (power of two, >= 64)
- ENG_W, 128, engine operand/result width (<= XLEN)
- NUM_ENG, 2, number of engine channels (1..(2^OP_W)-3)
- OP_W, 3, opcode width
- LANE_W, 32, extract lane width (<= XLEN)
- TIMEOUT, 1024, engine wait limit in cycles (used only with EXALU_TIMEOUT_EN)

Ports:
- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous, active-low reset
- req  in  1  request valid
- ready  out  1  request accepted when req&&ready
- op  in  OP_W  opcode
- d1  in  XLEN  operand 1
- d2  in  XLEN  operand 2
- respValid  out  1  result valid
- respReady  in  1  result consumed when respValid&&respReady
- result  out  XLEN  result
- error  out  1  qualifies result: illegal op or timeout
- busy  out  1  state!=IDLE or any engBusy
- engStart  out  NUM_ENG  one-cycle start pulse per engine
- engIn1  out  ENG_W  engine operand 1 (shared)
- engIn2  out  ENG_W  engine operand 2 / key (shared)
- engBusy  in  NUM_ENG  per-engine busy
- engOut  in  NUM_ENG*ENG_W  engine k result at [k*ENG_W +: ENG_W]

## Operation
- Opcode map: 0 NOP -> result 0. 1..NUM_ENG -> engine op-1. NUM_ENG+1 EXTRACT -> (d1 >> d2) & LANE mask. NUM_ENG+2 BYTELD -> ((d1 << 8) | d2[7:0]) truncated to XLEN. Any other code is illegal -> result 0, error=1.
- EXTRACT: shift amount is the full d2, unsigned. If d2 >= XLEN, result is 0.
- Engine result is zero-extended to XLEN. engIn1/engIn2 = captured d1/d2 [ENG_W-1:0], held stable from START until the block leaves WAIT.
- On accept, op/d1/d2 are captured in registers. Inputs are not sampled again until the next accept.
- FSM states:
  - IDLE: ready=1. Accept of NOP/EXTRACT/BYTELD/illegal -> DONE with result computed. Accept of an engine op -> START.
  - START: engStart[k]=1 for exactly this cycle -> WAIT.
  - WAIT: when engBusy[k]==0, capture engOut slice k -> DONE. The engine raises busy in the cycle after start, so the first WAIT cycle already samples busy high.
  - DONE: respValid=1, result/error held stable. respValid&&respReady -> IDLE.
- ready=0 in every state except IDLE. There is no accept in the same cycle a response is consumed.
- busy also reflects engines running independently of this block.

## Timing
- Reset (async assert, sync-to-clock deassert by system): state IDLE, respValid 0, result 0, error 0, engStart 0, engIn1/engIn2 0, timeout counter 0. req is ignored while resetN is low.
- Single-cycle ops: accept at edge N, respValid high after edge N+1 (latency 1).
- Engine ops: accept at N, engStart high in cycle N+1, WAIT from N+2. respValid rises 1 cycle after the first WAIT cycle with engBusy low. Total latency = engine busy length + 2.
- respValid stays high indefinitely under respReady=0. Back-to-back throughput is one op per 2 cycles minimum.
- Reset mid-WAIT aborts the op with no response. The engine's own state is not reset by this block.
- engBusy bits of non-selected engines are ignored by the FSM.

## Configuration
- EXALU_TIMEOUT_EN defined: a counter clears on entering WAIT and increments each WAIT cycle. If it reaches TIMEOUT with engBusy[k] still 1 -> DONE with result 0, error=1. A late engine completion is discarded.
- Not defined: WAIT persists until engBusy[k]==0, and error is raised only for illegal opcodes.

## Test plan
- Reset: hold resetN=0 with req=1 -> ready=1, respValid=0, result=0, engStart=0. Release, then req op=3 (EXTRACT), d1=256'h...DEADBEEF_12345678, d2=32 -> result=32'hDEADBEEF after 1 cycle.
- BYTELD d1=1, d2=256'h1AB -> result=256'h1AB (0x100|0xAB). EXTRACT with d2=300 -> result 0, error 0.
- Engine op=1 with an engine model busy for 10 cycles, output 128'hCAFE -> one engStart[0] pulse, result={128'b0,128'hCAFE} at latency 12, engStart[1] never pulses.
- Backpressure: respReady=0 for 5 cycles in DONE -> result stable, ready=0, a new req is not accepted. Accept occurs in the cycle after the handshake.
- Illegal op=7 -> result 0, error=1, latency 1. Reset asserted mid-WAIT -> respValid stays 0, state IDLE.
- With EXALU_TIMEOUT_EN, TIMEOUT=16, engine stuck busy -> respValid with error=1, result 0 after 16 WAIT cycles. Without the macro -> no response.
